// File: rtl/tiempo_pkg.sv
// Shared constants and the BCD-to-segment glyph table for the time display.
package tiempo_pkg;

  localparam int NUM_DIGITS = 6;

  // Active-low segment patterns, bit order {g,f,e,d,c,b,a}
  localparam logic [6:0] SEG_BLANK = 7'b1111111;
  localparam logic [6:0] SEG_DASH  = 7'b0111111;

  // Exclusive upper bounds of each time field
  localparam logic [5:0] SEC_LIMIT  = 6'd60;
  localparam logic [5:0] MIN_LIMIT  = 6'd60;
  localparam logic [5:0] HOUR_LIMIT = 6'd24;

  // Standard active-low glyphs; anything outside 0-9 is blanked
  function automatic logic [6:0] seg7(input logic [3:0] bcd);
    logic [6:0] pattern;
    case (bcd)
      4'd0:    pattern = 7'b1000000;
      4'd1:    pattern = 7'b1111001;
      4'd2:    pattern = 7'b0100100;
      4'd3:    pattern = 7'b0110000;
      4'd4:    pattern = 7'b0011001;
      4'd5:    pattern = 7'b0010010;
      4'd6:    pattern = 7'b0000010;
      4'd7:    pattern = 7'b1111000;
      4'd8:    pattern = 7'b0000000;
      4'd9:    pattern = 7'b0010000;
      default: pattern = SEG_BLANK;
    endcase
    return pattern;
  endfunction

endpackage

// File: rtl/bin2bcd_2d.sv
// Two-digit binary-to-BCD split for a 6-bit field, with a range check
// against the field's exclusive limit.
module bin2bcd_2d
  import tiempo_pkg::*;
(
  input  logic [5:0] value,
  input  logic [5:0] limit,
  output logic [3:0] tens,
  output logic [3:0] units,
  output logic       valid
);

  logic [5:0] tens_x10;

  // Tens found by threshold compares (value tops out at 63, so six steps)
  always_comb begin
    tens     = 4'd0;
    tens_x10 = 6'd0;
    for (int t = 1; t <= 6; t++) begin
      if (value >= 6'(10 * t)) begin
        tens     = 4'(t);
        tens_x10 = 6'(10 * t);
      end
    end
    units = 4'(value - tens_x10);
    valid = (value < limit);
  end

endmodule

// File: rtl/visualizador_tiempo.sv
// Six-digit multiplexed seven-segment driver for hh.mm.ss. A snapshot of the
// time is taken once per frame so a frame never mixes two time values.
module visualizador_tiempo
  import tiempo_pkg::*;
#(
  parameter int SCAN_DIV = 50000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [5:0] sec,
  input  logic [5:0] min,
  input  logic [4:0] hour,
  output logic [5:0] an,
  output logic [6:0] seg,
  output logic       dp
);

  localparam int                CNT_W    = $clog2(SCAN_DIV);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SCAN_DIV - 1);

  logic [CNT_W-1:0] cnt;
  logic [2:0]       idx;
  logic             primed;
  logic [5:0]       s_sec;
  logic [5:0]       s_min;
  logic [4:0]       s_hour;

  logic             cnt_wrap;
  logic             frame_end;

  logic [3:0]       sec_t, sec_u, min_t, min_u, hour_t, hour_u;
  logic             sec_ok, min_ok, hour_ok;

  logic [5:0]       an_nxt;
  logic [6:0]       seg_nxt;
  logic             dp_nxt;

  assign cnt_wrap  = (cnt == CNT_LAST);
  assign frame_end = cnt_wrap && (idx == 3'd5);

  // Scan counters and snapshot; the first edge out of reset only primes
  // the snapshot, so the scan proper starts one cycle later
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt    <= '0;
      idx    <= 3'd0;
      primed <= 1'b0;
      s_sec  <= 6'd0;
      s_min  <= 6'd0;
      s_hour <= 5'd0;
    end else if (!primed) begin
      primed <= 1'b1;
      s_sec  <= sec;
      s_min  <= min;
      s_hour <= hour;
    end else begin
      cnt <= cnt_wrap ? '0 : cnt + 1'b1;
      if (cnt_wrap) begin
        idx <= (idx == 3'd5) ? 3'd0 : idx + 3'd1;
      end
      if (frame_end) begin
        s_sec  <= sec;
        s_min  <= min;
        s_hour <= hour;
      end
    end
  end

  bin2bcd_2d u_sec (
    .value (s_sec),
    .limit (SEC_LIMIT),
    .tens  (sec_t),
    .units (sec_u),
    .valid (sec_ok)
  );

  bin2bcd_2d u_min (
    .value (s_min),
    .limit (MIN_LIMIT),
    .tens  (min_t),
    .units (min_u),
    .valid (min_ok)
  );

  bin2bcd_2d u_hour (
    .value ({1'b0, s_hour}),
    .limit (HOUR_LIMIT),
    .tens  (hour_t),
    .units (hour_u),
    .valid (hour_ok)
  );

  // Digit mux: pick the BCD digit for idx, dash out an invalid field,
  // light the separators after hours and minutes on even seconds
  always_comb begin
    an_nxt  = ~(6'b000001 << idx);
    seg_nxt = SEG_BLANK;
    case (idx)
      3'd0:    seg_nxt = sec_ok  ? seg7(sec_u)  : SEG_DASH;
      3'd1:    seg_nxt = sec_ok  ? seg7(sec_t)  : SEG_DASH;
      3'd2:    seg_nxt = min_ok  ? seg7(min_u)  : SEG_DASH;
      3'd3:    seg_nxt = min_ok  ? seg7(min_t)  : SEG_DASH;
      3'd4:    seg_nxt = hour_ok ? seg7(hour_u) : SEG_DASH;
      3'd5:    seg_nxt = hour_ok ? seg7(hour_t) : SEG_DASH;
      default: seg_nxt = SEG_BLANK;
    endcase
    dp_nxt = !(((idx == 3'd2) || (idx == 3'd4)) && !s_sec[0]);
  end

  // Output registers; held dark until the snapshot has been primed
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      an  <= 6'b111111;
      seg <= SEG_BLANK;
      dp  <= 1'b1;
    end else if (primed) begin
      an  <= an_nxt;
      seg <= seg_nxt;
      dp  <= dp_nxt;
    end
  end

endmodule

// File: tb/tb_visualizador_tiempo.sv
// Directed bench for visualizador_tiempo with SCAN_DIV=4 (24-cycle frame).
module tb_visualizador_tiempo;

  localparam int SD = 4;

  localparam logic [6:0] G0 = 7'b1000000;
  localparam logic [6:0] G1 = 7'b1111001;
  localparam logic [6:0] G2 = 7'b0100100;
  localparam logic [6:0] G3 = 7'b0110000;
  localparam logic [6:0] G4 = 7'b0011001;
  localparam logic [6:0] G5 = 7'b0010010;
  localparam logic [6:0] G6 = 7'b0000010;
  localparam logic [6:0] G7 = 7'b1111000;
  localparam logic [6:0] G8 = 7'b0000000;
  localparam logic [6:0] G9 = 7'b0010000;
  localparam logic [6:0] GD = 7'b0111111;

  // dp per digit, bit d = expected dp level while digit d is shown
  localparam logic [5:0] DP_EVEN = 6'b101011;
  localparam logic [5:0] DP_ODD  = 6'b111111;

  localparam logic [13:0] RST_OUT = {6'b111111, 7'b1111111, 1'b1};

  typedef struct {
    logic [5:0]  s;
    logic [5:0]  m;
    logic [4:0]  h;
    logic [41:0] segs;
    logic [5:0]  dps;
    string       name;
  } vec_t;

  logic       clk;
  logic       rst;
  logic [5:0] sec;
  logic [5:0] min;
  logic [4:0] hour;
  logic [5:0] an;
  logic [6:0] seg;
  logic       dp;

  int n_checks = 0;
  int n_errors = 0;

  vec_t vecs [8];

  visualizador_tiempo #(.SCAN_DIV(SD)) dut (
    .clk  (clk),
    .rst  (rst),
    .sec  (sec),
    .min  (min),
    .hour (hour),
    .an   (an),
    .seg  (seg),
    .dp   (dp)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic logic [41:0] pk(input logic [6:0] d0, d1, d2, d3, d4, d5);
    return {d5, d4, d3, d2, d1, d0};
  endfunction

  task automatic check(input string name, input logic [13:0] act, input logic [13:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: an/seg/dp got %b/%b/%b expected %b/%b/%b", name,
               act[13:8], act[7:1], act[0], exp[13:8], exp[7:1], exp[0]);
    end
  endtask

  // Called right after the edge where idx0 output first appears. One sample
  // per cycle; optionally changes sec after sample chg_at, or stops (before
  // the next edge) after sample stop_at.
  task automatic run_frame(input logic [41:0] segs, input logic [5:0] dps, input string name,
                           input int chg_at, input logic [5:0] new_sec, input int stop_at);
    for (int c = 0; c < 6 * SD; c++) begin
      int d;
      logic [5:0] exp_an;
      d = c / SD;
      exp_an = ~(6'b000001 << d);
      @(negedge clk);
      check($sformatf("%s c%0d", name, c), {an, seg, dp}, {exp_an, segs[7*d +: 7], dps[d]});
      if (c == chg_at) sec = new_sec;
      if (c == stop_at) return;
      @(posedge clk);
    end
  endtask

  // Restart with given inputs; returns just after the 2nd edge after release
  task automatic restart(input logic [5:0] s, input logic [5:0] m, input logic [4:0] h);
    @(negedge clk);
    rst = 1'b0;
    sec = s; min = m; hour = h;
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    @(posedge clk);
  endtask

  initial begin
    vecs[0] = '{6'd56, 6'd34, 5'd12, pk(G6, G5, G4, G3, G2, G1), DP_EVEN, "t123456"};
    vecs[1] = '{6'd59, 6'd59, 5'd23, pk(G9, G5, G9, G5, G3, G2), DP_ODD,  "t235959"};
    vecs[2] = '{6'd0,  6'd0,  5'd0,  pk(G0, G0, G0, G0, G0, G0), DP_EVEN, "t000000"};
    vecs[3] = '{6'd61, 6'd10, 5'd25, pk(GD, GD, G0, G1, GD, GD), DP_ODD,  "oor_sec_hour"};
    vecs[4] = '{6'd9,  6'd8,  5'd7,  pk(G9, G0, G8, G0, G7, G0), DP_ODD,  "lead_zero"};
    vecs[5] = '{6'd60, 6'd59, 5'd23, pk(GD, GD, G9, G5, G3, G2), DP_EVEN, "sec_eq_60"};
    vecs[6] = '{6'd59, 6'd60, 5'd24, pk(G9, G5, GD, GD, GD, GD), DP_ODD,  "min60_hour24"};
    vecs[7] = '{6'd63, 6'd63, 5'd31, pk(GD, GD, GD, GD, GD, GD), DP_ODD,  "all_max"};

    rst = 1'b1; sec = 6'd0; min = 6'd0; hour = 5'd0;
    #1 rst = 1'b0;

    // Held in reset with moving inputs: outputs stay dark
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      check($sformatf("in_reset %0d", i), {an, seg, dp}, RST_OUT);
      sec = 6'(i * 7); min = 6'(i * 5 + 3); hour = 5'(i * 4);
    end

    // Release: still dark after the 1st edge, idx0 after the 2nd
    @(negedge clk);
    sec = 6'd56; min = 6'd34; hour = 5'd12;
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("edge1_dark", {an, seg, dp}, RST_OUT);
    @(posedge clk);

    // Coherence: change at idx2 ignored this frame, applied next
    run_frame(pk(G6, G5, G4, G3, G2, G1), DP_EVEN, "coh_f1", 2 * SD, 6'd57, -1);
    // Change just before the load edge is captured
    run_frame(pk(G7, G5, G4, G3, G2, G1), DP_ODD,  "coh_f2", 6 * SD - 2, 6'd58, -1);
    // Change just after the load edge waits a frame
    run_frame(pk(G8, G5, G4, G3, G2, G1), DP_EVEN, "coh_f3", 6 * SD - 1, 6'd59, -1);
    run_frame(pk(G8, G5, G4, G3, G2, G1), DP_EVEN, "coh_f4", -1, 6'd0, -1);
    run_frame(pk(G9, G5, G4, G3, G2, G1), DP_ODD,  "coh_f5", -1, 6'd0, -1);

    // Table-driven single frames from a fresh start
    for (int v = 0; v < 8; v++) begin
      restart(vecs[v].s, vecs[v].m, vecs[v].h);
      run_frame(vecs[v].segs, vecs[v].dps, vecs[v].name, -1, 6'd0, -1);
    end

    // Reset mid-scan at idx3, then restart with new time
    restart(6'd56, 6'd34, 5'd12);
    run_frame(pk(G6, G5, G4, G3, G2, G1), DP_EVEN, "pre_mid_rst", -1, 6'd0, 3 * SD);
    #2 rst = 1'b0;
    #1 check("mid_rst_async", {an, seg, dp}, RST_OUT);
    sec = 6'd59; min = 6'd59; hour = 5'd23;
    @(negedge clk);
    check("mid_rst_held", {an, seg, dp}, RST_OUT);
    rst = 1'b1;
    @(posedge clk);
    @(posedge clk);
    run_frame(pk(G9, G5, G9, G5, G3, G2), DP_ODD, "post_mid_rst", -1, 6'd0, -1);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
